// File: rtl/ahb_slave_decoder.sv
// ---------------------------------------------------------------------------
// ahb_slave_decoder
//
// Single-master AHB-lite address decoder and response multiplexer. It sits
// between the CPU master port and up to three slaves. Slave 1 is the on-chip
// SRAM controller. Slaves 2 and 3 are peripheral regions. Any address that
// matches no region goes to a built-in default slave. The default slave
// answers every unmapped NONSEQ/SEQ with a two-cycle ERROR response. It also
// records the first failing address in a sticky error status.
//
// Ports
//   pll_core_cpuclk       system clock, rising edge
//   pad_cpu_rst           synchronous active-high reset
//   haddr_m/htrans_m/hwrite_m   master address-phase signals
//   hrdata_m/hready_m/hresp_m   response returned to the master
//   hready_bcast          copy of hready_m, driven to every slave as HREADYIN
//   hsel_s1..hsel_s3      slave selects, decoded from the address only
//   hrdata_sN/hready_sN/hresp_sN  slave responses
//   err_clr               clears err_vld
//   err_vld/err_addr/err_write    sticky record of the first unmapped access
// ---------------------------------------------------------------------------
module ahb_slave_decoder #(
    parameter logic [31:0] S1_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFC_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S3_BASE = 32'h6000_0000,
    parameter logic [31:0] S3_MASK = 32'hF000_0000
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst,

    input  logic [31:0] haddr_m,
    input  logic [1:0]  htrans_m,
    input  logic        hwrite_m,
    output logic [31:0] hrdata_m,
    output logic        hready_m,
    output logic [1:0]  hresp_m,
    output logic        hready_bcast,

    output logic        hsel_s1,
    output logic        hsel_s2,
    output logic        hsel_s3,
    input  logic [31:0] hrdata_s1,
    input  logic [31:0] hrdata_s2,
    input  logic [31:0] hrdata_s3,
    input  logic        hready_s1,
    input  logic        hready_s2,
    input  logic        hready_s3,
    input  logic [1:0]  hresp_s1,
    input  logic [1:0]  hresp_s2,
    input  logic [1:0]  hresp_s3,

    input  logic        err_clr,
    output logic        err_vld,
    output logic [31:0] err_addr,
    output logic        err_write
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

    err_state_t  state_q;
    err_state_t  state_d;
    logic [1:0]  dsel_q;
    logic [1:0]  dec_sel;
    logic        match_s1;
    logic        match_s2;
    logic        match_s3;
    logic        unmapped;
    logic        def_ready;
    logic [1:0]  def_resp;
    logic        err_start;
    logic        err_capture;

    // Address-phase decode. Overlapping regions resolve S1 > S2 > S3.
    // The selects ignore htrans_m. A slave only acts when it also sees an
    // active transfer with HREADYIN high.
    always_comb begin
        match_s1 = ((haddr_m & S1_MASK) == S1_BASE);
        match_s2 = ((haddr_m & S2_MASK) == S2_BASE);
        match_s3 = ((haddr_m & S3_MASK) == S3_BASE);
        hsel_s1  = match_s1;
        hsel_s2  = match_s2 & ~match_s1;
        hsel_s3  = match_s3 & ~match_s1 & ~match_s2;
        unmapped = ~(match_s1 | match_s2 | match_s3);
        dec_sel  = 2'd0;
        if (hsel_s1) begin
            dec_sel = 2'd1;
        end else if (hsel_s2) begin
            dec_sel = 2'd2;
        end else if (hsel_s3) begin
            dec_sel = 2'd3;
        end
    end

    // An accepted NONSEQ/SEQ to an unmapped address starts an error response.
    // While the FSM is in ERR1, hready_m is low, so this cannot fire then.
    assign err_start = hready_m & htrans_m[1] & unmapped;

    // Data-phase select. IDLE/BUSY owe no data phase, so they park on the
    // default slave, which answers OKAY with zero wait.
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            dsel_q <= 2'd0;
        end else if (hready_m) begin
            dsel_q <= htrans_m[1] ? dec_sel : 2'd0;
        end
    end

    // Default-slave error FSM state register.
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and default-slave response. The ERROR response needs one
    // cycle with hready low, then one cycle with hready high.
    always_comb begin
        state_d   = state_q;
        def_ready = 1'b1;
        def_resp  = RESP_OKAY;
        unique case (state_q)
            ST_IDLE: begin
                if (err_start) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                def_ready = 1'b0;
                def_resp  = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                def_resp = RESP_ERROR;
                state_d  = err_start ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response mux driven by the registered data-phase select.
    always_comb begin
        hrdata_m = 32'h0;
        hready_m = def_ready;
        hresp_m  = def_resp;
        unique case (dsel_q)
            2'd1: begin
                hrdata_m = hrdata_s1;
                hready_m = hready_s1;
                hresp_m  = hresp_s1;
            end
            2'd2: begin
                hrdata_m = hrdata_s2;
                hready_m = hready_s2;
                hresp_m  = hresp_s2;
            end
            2'd3: begin
                hrdata_m = hrdata_s3;
                hready_m = hready_s3;
                hresp_m  = hresp_s3;
            end
            default: begin
            end
        endcase
    end

    assign hready_bcast = hready_m;

    // Sticky error status. A capture is allowed when nothing is held yet,
    // or when the held record is being cleared in the same cycle. In that
    // case the capture wins, so the new error is not lost.
    assign err_capture = err_start & (~err_vld | err_clr);

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            err_vld   <= 1'b0;
            err_addr  <= 32'h0;
            err_write <= 1'b0;
        end else if (err_capture) begin
            err_vld   <= 1'b1;
            err_addr  <= haddr_m;
            err_write <= hwrite_m;
        end else if (err_clr) begin
            err_vld <= 1'b0;
        end
    end

endmodule
